// File: rtl/core_pkg.sv
// core_pkg: immediate-format encodings, opcode constants and the buffered decode entry shared by control and datapath.
package core_pkg;
    localparam logic [2:0] IMM_R   = 3'd0;
    localparam logic [2:0] IMM_I   = 3'd1;
    localparam logic [2:0] IMM_S   = 3'd2;
    localparam logic [2:0] IMM_B   = 3'd3;
    localparam logic [2:0] IMM_U   = 3'd4;
    localparam logic [2:0] IMM_J   = 3'd5;
    localparam logic [2:0] IMM_CSR = 3'd6;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  immsel;
        logic [31:0] imm;
        logic        illegal;
    } entry_t;
endpackage

// File: rtl/immgen.sv
// immgen: builds the 32-bit immediate from instruction bits [31:7] for the selected format.
module immgen
    import core_pkg::*;
(
    input  logic [2:0]  immsel,
    input  logic [24:0] bits,
    output logic [31:0] imm
);
    // bits[k] is instruction bit k+7
    always_comb
        imm = immsel == IMM_I   ? {{20{bits[24]}}, bits[24:13]} :
              immsel == IMM_S   ? {{20{bits[24]}}, bits[24:18], bits[4:0]} :
              immsel == IMM_B   ? {{19{bits[24]}}, bits[24], bits[0], bits[23:18], bits[4:1], 1'b0} :
              immsel == IMM_U   ? {bits[24:5], 12'b0} :
              immsel == IMM_J   ? {{11{bits[24]}}, bits[24], bits[12:5], bits[13], bits[23:14], 1'b0} :
              immsel == IMM_CSR ? {27'b0, bits[12:8]} :
              32'b0;
endmodule

// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: decodes the immediate format at acceptance and buffers decoded entries in a 2-deep skid buffer.
module imm_decode_ctrl
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [2:0]  out_immsel,
    output logic [31:0] out_imm,
    output logic        out_illegal,
    output logic [15:0] illegal_cnt
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'(DEPTH);
    logic [1:0]  state, state_nx;
    logic        rdy, accept, drain, ill;
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [15:0] cnt;
    entry_t      head, tail, fresh;
    always_comb begin
        ill = 1'b0;
        case (in_inst[6:0])
            OP_REG:                    sel = IMM_R;
            OP_IMM, OP_LOAD, OP_JALR:  sel = IMM_I;
            OP_STORE:                  sel = IMM_S;
            OP_BRANCH:                 sel = IMM_B;
            OP_LUI, OP_AUIPC:          sel = IMM_U;
            OP_JAL:                    sel = IMM_J;
            OP_SYSTEM:                 sel = in_inst[14] ? IMM_CSR : IMM_I;
            default: begin
                sel = IMM_R;
                ill = 1'b1;
            end
        endcase
    end
    immgen u_immgen (
        .immsel(sel),
        .bits  (in_inst[31:7]),
        .imm   (imm)
    );
    assign fresh    = {in_inst, in_pc, sel, imm, ill};
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;
    assign state_nx = flush             ? EMPTY :
                      accept & !drain   ? state + 2'd1 :
                      drain & !accept   ? state - 2'd1 :
                      state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            rdy   <= 1'b1;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            rdy   <= state_nx != FULL;
            head  <= drain & state == FULL                          ? tail :
                     accept & (state == EMPTY | (state == ONE & drain)) ? fresh :
                     head;
            tail  <= accept & state == ONE & !drain ? fresh : tail;
            cnt   <= accept & ill & !flush & cnt != 16'hFFFF ? cnt + 16'd1 : cnt;
        end
    end
    assign in_ready    = rdy;
    assign out_valid   = state != EMPTY;
    assign {out_inst, out_pc, out_immsel, out_imm, out_illegal} = out_valid ? head : '0;
    assign illegal_cnt = cnt;
endmodule

// File: tb/tb_imm_decode_ctrl.sv
// tb_imm_decode_ctrl: randomized and directed scoreboard bench against a behavioural RISC-V immediate model.
module tb_imm_decode_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst, out_pc, out_imm;
    logic [2:0]  out_immsel;
    logic        out_illegal;
    logic [15:0] illegal_cnt;

    imm_decode_ctrl #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_immsel(out_immsel), .out_imm(out_imm), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  sel;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] m_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic ref_ill(input logic [31:0] i);
        case (i[6:0])
            7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] ref_sel(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67: return 3'd1;
            7'h23: return 3'd2;
            7'h63: return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h6F: return 3'd5;
            7'h73: return i[14] ? 3'd6 : 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // Standard RISC-V immediate formulas, assembled from the architectural field layout
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        case (ref_sel(i))
            3'd1: return 32'($signed(i[31:20]));
            3'd2: return 32'($signed({i[31:25], i[11:7]}));
            3'd3: return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'd4: return {i[31:12], 12'b0};
            3'd5: return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3'd6: return 32'(i[19:15]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        e.inst = i;
        e.pc   = p;
        e.sel  = ref_sel(i);
        e.imm  = ref_imm(i);
        e.ill  = ref_ill(i);
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [0:11];
        logic [6:0] op;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F, 7'h00};
        op = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 7) == 0) op = 7'($urandom);
        return {25'($urandom), op};
    endfunction

    // Monitor: compares head against the scoreboard and pops on each completed drain
    initial forever begin
        @(negedge clk);
        #3;
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
            chk("out_inst", out_inst, q[0].inst);
            chk("out_pc", out_pc, q[0].pc);
            chk("out_immsel", 32'(out_immsel), 32'(q[0].sel));
            chk("out_imm", out_imm, q[0].imm);
            chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
            if (out_ready && !flush) void'(q.pop_front());
        end else if (!out_valid) begin
            chk("empty_outs", out_inst | out_pc | out_imm | 32'(out_immsel) | 32'(out_illegal), 32'd0);
        end
    end

    // Driver-side scoreboard update: push expected entry on each accept
    initial forever begin
        @(negedge clk);
        #4;
        chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
        if (rst_n) begin
            if (flush) q.delete();
            else if (in_valid && in_ready) begin
                q.push_back(model(in_inst, in_pc));
                if (ref_ill(in_inst) && m_cnt != 16'hFFFF) m_cnt++;
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] p);
        int k = 0;
        in_valid = 1'b1;
        in_inst  = i;
        in_pc    = p;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) chk("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] c0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        out_ready = 1'b1;
        send(32'hFFF00093, 32'h100);
        chk("addi_sel", 32'(out_immsel), 32'd1);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        @(negedge clk);

        out_ready = 1'b0;
        send(32'hFE000EE3, 32'h200);
        send(32'h0000006F, 32'h204);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("b_sel", 32'(out_immsel), 32'd3);
        chk("b_imm", out_imm, ref_imm(32'hFE000EE3));
        out_ready = 1'b1;
        @(negedge clk);
        chk("j_sel", 32'(out_immsel), 32'd5);
        chk("j_pc", out_pc, 32'h204);
        @(negedge clk);
        chk("drained", 32'(out_valid), 32'd0);

        send(32'h3402D073, 32'h300);
        chk("csr_sel", 32'(out_immsel), 32'd6);
        chk("csr_imm", out_imm, ref_imm(32'h3402D073));
        @(negedge clk);

        out_ready = 1'b0;
        send(32'h00000013, 32'h400);
        send(32'h00001037, 32'h404);
        c0 = illegal_cnt;
        in_valid = 1'b1;
        in_inst  = 32'hFFFFFFFF;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_cnt", 32'(illegal_cnt), 32'(c0));

        send(32'h00500113, 32'h500);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_outs", out_inst | out_pc | out_imm | 32'(out_immsel) | 32'(out_illegal), 32'd0);
        q.delete();
        m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            send({25'(n * 3 + 1), 7'b1111111}, 32'(n));
            chk("ill_flag", 32'(out_illegal), 32'd1);
        end
        chk("ill_cnt3", 32'(illegal_cnt), 32'd3);
        @(negedge clk);

        force dut.cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.cnt;
        send(32'hFFFFFFFF, 32'h600);
        @(negedge clk);
        chk("ill_sat", 32'(illegal_cnt), 32'hFFFF);

        for (int n = 0; n < 400; n++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 19) == 0;
            in_inst   = rand_inst();
            in_pc     = $urandom;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("final_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
